// File: rtl/pad_tx_arbiter.sv
// pad_tx_arbiter: round-robin arbiter that serialises one framed word per
// grant onto a narrow bank of slow output pads. Frame = one header beat
// carrying the requester ID, then DATA_W/PAD_W data beats, MSB first. Each
// beat is held HOLD cycles with a strobe in its second half.
module pad_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int PAD_W   = 4,
  parameter int HOLD    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [PAD_W-1:0]          pad_data,
  output logic                      pad_strobe,
  output logic                      pad_frame,
  output logic                      busy
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NBEATS = DATA_W / PAD_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_HALF = HOLD_W'(HOLD / 2);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t              state_q,  state_d;
  logic [ID_W-1:0]     ptr_q,    ptr_d;
  logic [ID_W-1:0]     id_q,     id_d;
  logic [DATA_W-1:0]   shift_q,  shift_d;
  logic [BEAT_W-1:0]   beat_q,   beat_d;
  logic [HOLD_W-1:0]   hold_q,   hold_d;
  logic [PAD_W-1:0]    pad_data_q,   pad_data_d;
  logic                pad_strobe_q, pad_strobe_d;
  logic                pad_frame_q,  pad_frame_d;
  logic                busy_q,       busy_d;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_vld;
  logic [ID_W-1:0]      grant_id;
  logic                 start;
  logic [DATA_W-1:0]    win_data;

  // Round-robin search: rotate valids so the pointer sits at bit 0, take the
  // first set bit, then map the offset back to an absolute requester index.
  always_comb begin
    logic [ID_W:0] sum;
    valid_dbl = {req_valid, req_valid};
    valid_rot = NUM_REQ'(valid_dbl >> ptr_q);
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && valid_rot[k]) begin
        grant_vld = 1'b1;
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        grant_id = sum[ID_W-1:0];
      end
    end
  end

  assign start = (state_q == IDLE) && en && grant_vld;

  // One-hot accept pulse and mux of the winner's word
  always_comb begin
    req_ready = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_ready[i] = start;
        win_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Frame sequencing: next state, counters, capture and pointer update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          id_d    = grant_id;
          shift_d = win_data;
          beat_d  = '0;
          hold_d  = '0;
          ptr_d   = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
        end
      end
      HDR: begin
        if (hold_q == HOLD_LAST) begin
          state_d = DATA;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      DATA: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (beat_q == BEAT_LAST) begin
            state_d = GAP;
            beat_d  = '0;
            shift_d = '0;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            shift_d = shift_q << PAD_W;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad values for the next cycle, derived from next-state values so the
  // pads come straight from flops yet line up with the state they describe
  always_comb begin
    pad_frame_d  = (state_d == HDR) || (state_d == DATA);
    pad_strobe_d = pad_frame_d && (hold_d >= HOLD_HALF);
    pad_data_d   = '0;
    if (state_d == HDR)       pad_data_d = PAD_W'(id_d);
    else if (state_d == DATA) pad_data_d = shift_d[DATA_W-1 -: PAD_W];
    busy_d       = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      shift_q      <= '0;
      beat_q       <= '0;
      hold_q       <= '0;
      pad_data_q   <= '0;
      pad_strobe_q <= 1'b0;
      pad_frame_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      shift_q      <= shift_d;
      beat_q       <= beat_d;
      hold_q       <= hold_d;
      pad_data_q   <= pad_data_d;
      pad_strobe_q <= pad_strobe_d;
      pad_frame_q  <= pad_frame_d;
      busy_q       <= busy_d;
    end
  end

  assign pad_data   = pad_data_q;
  assign pad_strobe = pad_strobe_q;
  assign pad_frame  = pad_frame_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pad_tx_arbiter.sv
// Bench for pad_tx_arbiter: scoreboard of expected (id, word) frames fed by
// the stimulus; a negedge monitor decodes grants and pad frames against it.
module tb_pad_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int PW = 4;
  localparam int HD = 4;
  localparam int FRAME_CYC = HD * (1 + DW/PW);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [PW-1:0]    pad_data;
  logic             pad_strobe, pad_frame, busy;

  pad_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PAD_W(PW), .HOLD(HD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pad_data(pad_data), .pad_strobe(pad_strobe),
    .pad_frame(pad_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [DW-1:0] word; } exp_t;
  exp_t exp_q[$];
  int   grant_log[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, grants = 0, frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: match grants to the scoreboard, decode each frame at the pads
  initial begin
    exp_t cur;
    int pos = 0, gcyc = 0;
    bit inflight = 0;
    logic [PW-1:0] nib = '0, hdr = '0;
    logic [DW-1:0] word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos = 0; inflight = 0;
      end else begin
        if (req_ready != '0) begin
          if (exp_q.size() == 0) chk("unexp_grant", 64'(req_ready), 64'(0));
          else begin
            cur = exp_q.pop_front();
            chk("grant", 64'(req_ready), 64'(1) << cur.id);
            inflight = 1; gcyc = cyc;
            grant_log.push_back(cyc);
            grants++;
          end
        end
        if (pad_frame) begin
          if (pos == 0) chk("frame_start", 64'(cyc - gcyc), 64'(1));
          chk("busy_frame", 64'(busy), 64'(1));
          chk("strobe", 64'(pad_strobe), 64'((pos % HD) >= HD/2));
          if (pos % HD == 0) begin
            nib = pad_data;
            if (pos == 0) hdr = pad_data;
            else word = {word[DW-PW-1:0], pad_data};
          end else chk("stable", 64'(pad_data), 64'(nib));
          pos++;
        end else if (pos > 0) begin
          chk("frame_len", 64'(pos), 64'(FRAME_CYC));
          chk("gap_pads", 64'({pad_data, pad_strobe}), 64'(0));
          chk("gap_busy", 64'(busy), 64'(1));
          if (inflight) begin
            chk("hdr_id", 64'(hdr), 64'(cur.id));
            chk("word", 64'(word), 64'(cur.word));
          end else chk("frame_noexp", 64'(1), 64'(0));
          inflight = 0; pos = 0;
          frames++;
        end
      end
    end
  end

  task automatic set_word(input int i, input logic [DW-1:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  task automatic expect_frame(input int id, input logic [DW-1:0] w);
    exp_t e;
    e.id = id; e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b = 0;
    while (grants < n && b < budget) begin @(posedge clk); b++; end
    if (grants < n) chk("grant_timeout", 64'(grants), 64'(n));
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int b = 0;
    while (frames < n && b < budget) begin @(posedge clk); b++; end
    if (frames < n) chk("frame_timeout", 64'(frames), 64'(n));
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, f0;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0;
    do_reset();
    en = 1'b1;

    // Idle after reset: nothing moves with no requester valid
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 64'({req_ready, pad_data, pad_strobe, pad_frame, busy}), 64'(0));
    end

    // Single frame from requester 2; valid and data change after the grant
    @(posedge clk); #1;
    set_word(2, 32'hDEADBEEF);
    expect_frame(2, 32'hDEADBEEF);
    req_valid = 4'b0100;
    wait_grants(1, 100);
    req_valid = '0;
    set_word(2, 32'h12345678);
    wait_frames(1, 100);

    // Pointer now at 3: valid 1001 must grant 3 then 0
    set_word(3, 32'hA5A50003);
    set_word(0, 32'h0F0F1000);
    expect_frame(3, 32'hA5A50003);
    expect_frame(0, 32'h0F0F1000);
    req_valid = 4'b1001;
    wait_grants(3, 100);
    req_valid = '0;
    wait_frames(3, 100);

    // Round robin from a fresh pointer, all requesters continuously valid
    do_reset();
    for (int i = 0; i < NR; i++) set_word(i, 32'h13579BDF ^ (32'h11111111 * (i + 1)));
    for (int i = 0; i < 5; i++) expect_frame(i % NR, 32'h13579BDF ^ (32'h11111111 * ((i % NR) + 1)));
    g0 = grants; f0 = frames;
    req_valid = 4'b1111;
    wait_grants(g0 + 5, 300);
    req_valid = '0;
    wait_frames(f0 + 5, 300);
    for (int i = 1; i < 5; i++)
      chk("rr_spacing", 64'(grant_log[g0+i] - grant_log[g0+i-1]), 64'(38));

    // en falls mid-frame: frame completes, then no grants until en returns
    set_word(0, 32'hC0FFEE00);
    expect_frame(0, 32'hC0FFEE00);
    g0 = grants; f0 = frames;
    req_valid = 4'b0001;
    wait_grants(g0 + 1, 100);
    repeat (9) @(posedge clk);
    #1 en = 1'b0;
    wait_frames(f0 + 1, 100);
    @(negedge clk);
    chk("busy_after_gap", 64'(busy), 64'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("en0_no_ready", 64'(req_ready), 64'(0));
    end
    set_word(0, 32'hFACE0001);
    expect_frame(0, 32'hFACE0001);
    @(posedge clk); #1 en = 1'b1;
    #1 chk("en_rise_grant", 64'(req_ready), 64'(4'b0001));
    wait_grants(g0 + 2, 100);
    req_valid = '0;
    wait_frames(f0 + 2, 100);

    // Reset during the third data beat aborts the frame; pointer restarts at 0
    set_word(1, 32'h87654321);
    expect_frame(1, 32'h87654321);
    g0 = grants; f0 = frames;
    req_valid = 4'b0010;
    wait_grants(g0 + 1, 100);
    req_valid = '0;
    repeat (12) @(posedge clk);
    #2 chk("pre_rst_frame", 64'(pad_frame), 64'(1));
    #1 rst_n = 1'b0;
    #1 chk("rst_async", 64'({pad_data, pad_strobe, pad_frame, busy}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_word(0, 32'h0BADF00D);
    set_word(3, 32'h33333333);
    expect_frame(0, 32'h0BADF00D);
    req_valid = 4'b1001;
    wait_grants(g0 + 2, 100);
    req_valid = '0;
    wait_frames(f0 + 1, 100);

    chk("exp_left", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
